eic: RTL and testbench
======================

// Module: eic
// PURPOSE
//  External interrupt controller for a MIPS-style EIC-mode CPU core.
//  - Collects up to 32 interrupt sources: the low channels are level (direct), the next channels are rising-edge (sense).
//  - Applies a per-channel mask and selects the highest-numbered active request.
//  - Presents that request to the core as a registered priority level (EIC_Interrupt) and vector (EIC_Vector).
// PARAMETERS
//  EIC_DIRECT_CHANNELS  16  level-sensitive channels, mapped to signal[EIC_DIRECT_CHANNELS-1:0]
//  EIC_SENSE_CHANNELS   16  rising-edge channels, mapped to the next EIC_SENSE_CHANNELS bits
//  Constraint: DIRECT + SENSE <= 32 (elaboration error otherwise). Bits above DIRECT+SENSE are unused; their request bits are tied 0.
// PORTS
//  CLK            in   1   system clock, all state on rising edge
//  RESETn         in   1   reset; asynchronous, active-high (asserted = 1), despite the legacy name
//  signal         in   32  raw interrupt inputs, synchronous to CLK
//  mask           in   32  per-channel enable, 1 = enabled
//  EIC_Interrupt  out  8   requested priority level: winning channel index + 1; 0 = no interrupt
//  EIC_Vector     out  6   winning channel index [5:0]; 0 when no interrupt
//  request        out  32  registered pending-request vector (debug visibility)
// BEHAVIOUR
//  Reset (RESETn=1, async)
//   - request, EIC_Interrupt, EIC_Vector, the sense pending bits and the previous-signal register all clear to 0.
//  Edge detection
//   - signal_r <= signal every cycle.
//   - rise = signal & ~signal_r.
//  Direct channel i (i < DIRECT)
//   - request[i] <= signal[i] & mask[i].
//   - Pure level: the request follows the input with one cycle of latency.
//  Sense channel i (DIRECT <= i < DIRECT+SENSE)
//   - pending[i] is set when rise[i] & mask[i], and stays set after the input falls.
//   - pending[i] is cleared only when mask[i] = 0. This is the acknowledge mechanism: software masks the channel, then unmasks it.
//   - request[i] = pending[i], registered. Set has priority over hold; clear happens when masked.
//   - A rise while the channel is masked is discarded, not remembered.
//  Priority encoding
//   - Registered from request. The highest set request index k wins.
//   - EIC_Interrupt <= k+1 and EIC_Vector <= k.
//   - If request == 0, both outputs are 0.
//  Latency
//   - Input change at edge N is visible on request at edge N+1 and on EIC_Interrupt/EIC_Vector at edge N+2.
//  Simultaneous events
//   - Multiple new requests in one cycle: the highest index wins; lower ones remain pending or level.
//   - Mask drop and rise in the same cycle: clear wins (channel is masked).
//  Release: when the winning level source is deasserted, the output falls back to the next-highest active request, or to 0.
//  Reset mid-operation clears all pending state immediately, with no clock required.
// TESTING
//  1 Reset held 2 cycles, signal=0, mask=0xFFFF -> request=0, EIC_Interrupt=0, EIC_Vector=0.
//  2 Direct channels, mask=0xFFFF:
//    - signal[0]=1 -> EIC_Interrupt=1, Vector=0.
//    - add signal[5] -> 6 / 5.
//    - add signal[12] -> 13 / 12.
//    - drop 12 -> 6 / 5; drop 5 -> 1 / 0.
//    - Each change appears 2 edges later.
//  3 Mask: signal[5]=1 with mask[5]=0 -> request[5]=0; the output shows the next lower active channel, or 0.
//  4 Sense channel 20 (mask[20]=1):
//    - one-cycle pulse on signal[20] -> request[20] stays 1, EIC_Interrupt=21, Vector=20 after the pulse ends.
//    - mask[20]=0 -> cleared; re-enable without an edge -> stays 0.
//  5 Masked edge: pulse signal[20] with mask[20]=0, then unmask -> request[20]=0.
//  6 Async reset asserted mid-cycle with requests pending -> all outputs 0 before the next CLK edge.

Source files
------------

// File: rtl/eic.sv
// External interrupt controller for an EIC-mode core: level and rising-edge
// channels, per-channel masking, and a registered highest-index priority output.
module eic #(
  parameter int unsigned EIC_DIRECT_CHANNELS = 16,
  parameter int unsigned EIC_SENSE_CHANNELS  = 16
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic [31:0] signal,
  input  logic [31:0] mask,
  output logic [7:0]  EIC_Interrupt,
  output logic [5:0]  EIC_Vector,
  output logic [31:0] request
);

  localparam int unsigned TOTAL_CHANNELS = EIC_DIRECT_CHANNELS + EIC_SENSE_CHANNELS;
  localparam logic [63:0] ONE64          = 64'd1;
  // Channel-class selectors; bits above the configured channels are in neither.
  localparam logic [31:0] DIRECT_BITS    = 32'((ONE64 << EIC_DIRECT_CHANNELS) - ONE64);
  localparam logic [31:0] SENSE_BITS     =
    32'(((ONE64 << EIC_SENSE_CHANNELS) - ONE64) << EIC_DIRECT_CHANNELS);

  generate
    if (TOTAL_CHANNELS > 32) begin : g_cfg_check
      $error("eic: EIC_DIRECT_CHANNELS + EIC_SENSE_CHANNELS must not exceed 32");
    end
  endgenerate

  logic [31:0] signal_r;
  logic [31:0] rise;
  logic [31:0] pending;
  logic [31:0] pending_nxt;
  logic [31:0] request_nxt;
  logic [7:0]  irq_nxt;
  logic [5:0]  vec_nxt;

  // Sense-channel pending bits live in the request register itself.
  assign pending = request & SENSE_BITS;

  // Next request: masked levels plus sticky edges; masking clears, even on a same-cycle rise.
  always_comb begin
    rise        = signal & ~signal_r;
    pending_nxt = (pending | rise) & mask & SENSE_BITS;
    request_nxt = (signal & mask & DIRECT_BITS) | pending_nxt;
  end

  // Highest set request index wins; level is index + 1, zero when idle.
  always_comb begin
    irq_nxt = 8'd0;
    vec_nxt = 6'd0;
    for (int i = 0; i < 32; i++) begin
      if (request[i]) begin
        irq_nxt = 8'(i + 1);
        vec_nxt = 6'(i);
      end
    end
  end

  // Edge-detect history and request state.
  always_ff @(posedge CLK or posedge RESETn) begin
    if (RESETn) begin
      signal_r <= 32'd0;
      request  <= 32'd0;
    end else begin
      signal_r <= signal;
      request  <= request_nxt;
    end
  end

  // Registered priority outputs to the core.
  always_ff @(posedge CLK or posedge RESETn) begin
    if (RESETn) begin
      EIC_Interrupt <= 8'd0;
      EIC_Vector    <= 6'd0;
    end else begin
      EIC_Interrupt <= irq_nxt;
      EIC_Vector    <= vec_nxt;
    end
  end

endmodule

// File: tb/tb_eic.sv
// Scoreboard bench for eic: stimulus queues expected state with a due cycle,
// a monitor checks the DUT one time unit after each rising edge.
module tb_eic;

  logic        CLK;
  logic        RESETn;
  logic [31:0] signal;
  logic [31:0] mask;
  logic [7:0]  EIC_Interrupt;
  logic [5:0]  EIC_Vector;
  logic [31:0] request;

  eic #(.EIC_DIRECT_CHANNELS(16), .EIC_SENSE_CHANNELS(16)) dut (
    .CLK          (CLK),
    .RESETn       (RESETn),
    .signal       (signal),
    .mask         (mask),
    .EIC_Interrupt(EIC_Interrupt),
    .EIC_Vector   (EIC_Vector),
    .request      (request)
  );

  typedef struct {
    int          due;
    logic [31:0] req;
    logic [7:0]  irq;
    logic [5:0]  vec;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_miss = 0;

  localparam logic [31:0] M_DIRECT = 32'h0000_FFFF;
  localparam logic [31:0] BIT20    = 32'h0010_0000;
  localparam logic [31:0] BIT25    = 32'h0200_0000;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name,
                       input logic [31:0] er, input logic [7:0] ei, input logic [5:0] ev);
    n_vec++;
    if (request !== er || EIC_Interrupt !== ei || EIC_Vector !== ev) begin
      n_miss++;
      $display("FAIL %s: got req=%h irq=%0d vec=%0d, expected req=%h irq=%0d vec=%0d",
               name, request, EIC_Interrupt, EIC_Vector, er, ei, ev);
    end
  endtask

  task automatic expect_at(input int d, input logic [31:0] er, input logic [7:0] ei,
                           input logic [5:0] ev, input string name);
    exp_t e;
    e.due = cyc + d; e.req = er; e.irq = ei; e.vec = ev; e.name = name;
    sb.push_back(e);
  endtask

  // Drive a new input pattern and expect its full effect two edges later.
  task automatic vec(input logic [31:0] s, input logic [31:0] m, input logic [31:0] er,
                     input logic [7:0] ei, input logic [5:0] ev, input string name);
    @(negedge CLK);
    signal = s;
    mask   = m;
    expect_at(2, er, ei, ev, name);
    repeat (2) @(negedge CLK);
  endtask

  // One-cycle pulse of bits p over base level, then expect the settled state.
  task automatic pulse(input logic [31:0] p, input logic [31:0] base, input logic [31:0] m,
                       input logic [31:0] er, input logic [7:0] ei, input logic [5:0] ev,
                       input string name);
    @(negedge CLK);
    signal = base | p;
    mask   = m;
    @(negedge CLK);
    signal = base;
    expect_at(2, er, ei, ev, name);
    repeat (2) @(negedge CLK);
  endtask

  // Monitor: pops every expectation due at this edge and compares.
  initial begin
    forever begin
      @(posedge CLK);
      cyc++;
      #1;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        if (e.due < cyc) begin
          n_vec++;
          n_miss++;
          $display("FAIL %s: check missed, due cycle %0d, now %0d", e.name, e.due, cyc);
        end else begin
          check(e.name, e.req, e.irq, e.vec);
        end
      end
    end
  end

  // Global watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // Directed stimulus.
  initial begin
    RESETn = 1'b1;
    signal = 32'd0;
    mask   = M_DIRECT;
    repeat (2) @(negedge CLK);
    RESETn = 1'b0;
    expect_at(1, 32'd0, 8'd0, 6'd0, "reset_state");
    repeat (2) @(negedge CLK);

    // Direct channels, plus a latency probe one edge after a change.
    vec(32'h0000_0001, M_DIRECT, 32'h0000_0001, 8'd1, 6'd0, "direct_0");
    @(negedge CLK);
    signal = 32'h0000_0021;
    expect_at(1, 32'h0000_0021, 8'd1, 6'd0, "latency_req_first");
    expect_at(2, 32'h0000_0021, 8'd6, 6'd5, "direct_5");
    repeat (2) @(negedge CLK);
    vec(32'h0000_1021, M_DIRECT, 32'h0000_1021, 8'd13, 6'd12, "direct_12");
    vec(32'h0000_0021, M_DIRECT, 32'h0000_0021, 8'd6,  6'd5,  "drop_12");
    vec(32'h0000_0001, M_DIRECT, 32'h0000_0001, 8'd1,  6'd0,  "drop_5");

    // Masking a level channel.
    vec(32'h0000_0021, 32'h0000_FFDF, 32'h0000_0001, 8'd1, 6'd0, "mask5_fallback");
    vec(32'h0000_0020, 32'h0000_FFDF, 32'h0000_0000, 8'd0, 6'd0, "mask5_idle");

    // Sense channel 20: sticky after pulse, cleared by mask, no re-arm on unmask.
    vec(32'd0, M_DIRECT | BIT20, 32'd0, 8'd0, 6'd0, "sense_idle");
    pulse(BIT20, 32'd0, M_DIRECT | BIT20, BIT20, 8'd21, 6'd20, "sense20_sticky");
    vec(32'd0, M_DIRECT, 32'd0, 8'd0, 6'd0, "sense20_ack");
    vec(32'd0, M_DIRECT | BIT20, 32'd0, 8'd0, 6'd0, "sense20_reenable");

    // Rise while masked is discarded.
    pulse(BIT20, 32'd0, M_DIRECT, 32'd0, 8'd0, 6'd0, "masked_edge");
    vec(32'd0, M_DIRECT | BIT20, 32'd0, 8'd0, 6'd0, "masked_edge_unmask");

    // Simultaneous rises: highest wins, lower stays pending.
    pulse(BIT20 | BIT25, 32'd0, M_DIRECT | BIT20 | BIT25, BIT20 | BIT25, 8'd26, 6'd25,
          "dual_sense");
    vec(32'd0, M_DIRECT | BIT20, BIT20, 8'd21, 6'd20, "ack25_fallback20");
    vec(32'h0000_0008, M_DIRECT | BIT20, BIT20 | 32'h8, 8'd21, 6'd20, "sense_over_level");

    // Mask drop and rise on the same channel in the same cycle: clear wins.
    vec(BIT20 | 32'h8, M_DIRECT, 32'h0000_0008, 8'd4, 6'd3, "drop_and_rise");
    vec(32'h0000_0008, M_DIRECT | BIT20, 32'h0000_0008, 8'd4, 6'd3, "fall_no_rearm");

    // Async reset mid-cycle with a pending sense request.
    pulse(BIT20, 32'h8, M_DIRECT | BIT20, BIT20 | 32'h8, 8'd21, 6'd20, "pre_reset_pending");
    @(posedge CLK);
    #3;
    RESETn = 1'b1;
    #1;
    check("async_reset", 32'd0, 8'd0, 6'd0);
    @(negedge CLK);
    signal = 32'd0;
    RESETn = 1'b0;
    vec(32'd0, M_DIRECT | BIT20, 32'd0, 8'd0, 6'd0, "post_reset_cleared");
    vec(32'h0000_0001, M_DIRECT | BIT20, 32'h0000_0001, 8'd1, 6'd0, "post_reset_direct");

    // Drain any outstanding expectations within a bounded window.
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge CLK);
    if (sb.size() > 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: %0d expectations never checked", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
